mul_add_seq: RTL and testbench



---
 rtl/mul_add_seq_pkg.sv | 12 +
 rtl/mul_add_seq_if.sv | 22 ++
 rtl/mul_add_seq.sv | 69 ++++++
 tb/tb_mul_add_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mul_add_seq_pkg.sv
// Shared arithmetic definitions for the multiply-accumulate unit and the divider.
package arith_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mul_add_seq_if.sv
// Operand/result bundle between a requester and mul_add_seq.
interface mul_add_seq_if #(
    parameter int unsigned WIDTH = arith_pkg::DEF_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output product, busy, done
    );
endinterface

// File: rtl/mul_add_seq.sv
// Shift-and-add multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit retired per clock.
module mul_add_seq
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic         clk,
    input logic         rst,
    mul_add_seq_if.slave bus
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   partial;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   product;

    always_comb begin
        partial  = {{WIDTH{1'b0}}, mcand_q} << cnt;
        acc_next = mplier_q[cnt] ? acc + partial : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mcand_q  <= bus.multiplicand;
                        mplier_q <= bus.multiplier;
                        acc      <= {{WIDTH{1'b0}}, bus.addend};
                        cnt      <= '0;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    // cnt parks on LAST instead of wrapping; it is reloaded on the next start
                    if (cnt == LAST) begin
                        product <= acc_next;
                        state   <= DONE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.product = product;
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: table vectors, corner sequences and a full sweep.
module tb_mul_add_seq;
    import arith_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    mul_add_seq_if #(.WIDTH(W)) bus ();

    mul_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t q[$];
    vec_t last_pop;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1ns later; any done pulse retires the oldest pending op.
    task automatic tick(output bit seen);
        vec_t e;
        @(posedge clk);
        #1;
        seen = bus.done;
        if (bus.done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got done=1 required no pending operation");
            end else begin
                e = q.pop_front();
                last_pop = e;
                check($sformatf("product %0d*%0d+%0d", e.a, e.b, e.c),
                      int'(bus.product), int'(e.exp));
            end
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic s);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        bus.start        = s;
    endtask

    task automatic run_op(input vec_t v);
        bit seen;
        int busy_cnt;
        int lat;
        drive(v.a, v.b, v.c, 1'b1);
        q.push_back(v);
        tick(seen);
        drive(4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
        busy_cnt = 0;
        lat      = 0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            if (bus.busy) busy_cnt++;
            tick(seen);
            lat = k;
        end
        check("latency", lat, int'(W));
        check("busy_cycles", busy_cnt, int'(W));
        tick(seen);
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    vec_t tbl[8];

    initial begin
        bit seen;
        int dones;
        int t;
        int t_last;
        int ndone;
        int idx;
        vec_t v;

        tbl[0] = '{a: 4'd7,  b: 4'd3,  c: 4'd2,  exp: 8'd23};
        tbl[1] = '{a: 4'd15, b: 4'd15, c: 4'd14, exp: 8'd239};
        tbl[2] = '{a: 4'd15, b: 4'd15, c: 4'd15, exp: 8'd240};
        tbl[3] = '{a: 4'd0,  b: 4'd9,  c: 4'd5,  exp: 8'd5};
        tbl[4] = '{a: 4'd9,  b: 4'd0,  c: 4'd0,  exp: 8'd0};
        tbl[5] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  exp: 8'd1};
        tbl[6] = '{a: 4'd15, b: 4'd1,  c: 4'd0,  exp: 8'd15};
        tbl[7] = '{a: 4'd8,  b: 4'd8,  c: 4'd8,  exp: 8'd72};

        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_product", int'(bus.product), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Reset in the middle of RUN discards the in-flight op
        drive(4'd7, 4'd3, 4'd2, 1'b1);
        q.push_back(tbl[0]);
        tick(seen);
        bus.start = 1'b0;
        tick(seen);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset_busy", int'(bus.busy), 0);
        check("midrun_reset_done", int'(bus.done), 0);
        check("midrun_reset_product", int'(bus.product), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(tbl[0]);
        for (int k = 0; k < 8; k++) tick(seen);

        // Start while busy is ignored
        drive(4'd6, 4'd5, 4'd1, 1'b1);
        q.push_back('{a: 4'd6, b: 4'd5, c: 4'd1, exp: 8'd31});
        tick(seen);
        bus.start = 1'b0;
        tick(seen);
        drive(4'd2, 4'd2, 4'd0, 1'b1);
        tick(seen);
        bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick(seen);
            if (seen) dones++;
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_pending", q.size(), 0);

        // Back-to-back sweep with start held high
        idx = 0;
        v.a = 4'(idx >> 8); v.b = 4'(idx >> 4); v.c = 4'(idx);
        v.exp = 8'(v.a) * 8'(v.b) + 8'(v.c);
        drive(v.a, v.b, v.c, 1'b1);
        q.push_back(v);
        t = 0; t_last = 0; ndone = 0;
        while (ndone < 4096 && t < 4096 * 6 + 20) begin
            tick(seen);
            t++;
            if (seen) begin
                if (ndone > 0) check("b2b_interval", t - t_last, int'(W) + 1);
                if (last_pop.c < last_pop.a)
                    check($sformatf("roundtrip %0d*%0d+%0d", last_pop.a, last_pop.b, last_pop.c),
                          (int'(bus.product) / int'(last_pop.a)) * 16 + int'(bus.product) % int'(last_pop.a),
                          int'(last_pop.b) * 16 + int'(last_pop.c));
                t_last = t;
                ndone++;
                idx++;
                if (idx < 4096) begin
                    v.a = 4'(idx >> 8); v.b = 4'(idx >> 4); v.c = 4'(idx);
                    v.exp = 8'(v.a) * 8'(v.b) + 8'(v.c);
                    drive(v.a, v.b, v.c, 1'b1);
                    q.push_back(v);
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        check("sweep_results", ndone, 4096);
        check("sweep_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
